adc_frame_loader: RTL

- Upstream feeder for the FFT core: buffers free-running ADC samples in a synchronous FIFO and exports full/empty status.
- Whenever a complete frame is buffered, streams exactly FRAME_N samples into the FFT input port under the FFT's ready-for-data handshake.
- After every reset, issues the one-cycle scale_sch/fwd_inv configuration write the FFT core requires, before any data is sent.

---
 rtl/adc_frame_loader.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/adc_frame_loader.sv
// ADC sample FIFO feeding an FFT core: buffers samples, issues the one-shot
// configuration write after reset and streams whole frames under fft_rfd.
module adc_frame_loader #(
  parameter int                 DATA_W    = 8,
  parameter int                 ADDR_W    = 11,
  parameter int                 FRAME_N   = 1024,
  parameter int                 IDX_W     = 10,
  parameter int                 SCALE_W   = 10,
  parameter logic [SCALE_W-1:0] SCALE_SCH = 10'h2AA,
  parameter logic               FWD_INV   = 1'b1
) (
  input  logic               clk,
  input  logic               reset_fifo,
  input  logic [DATA_W-1:0]  adc_data,
  input  logic               adc_valid,
  output logic               full,
  output logic               empty,
  output logic               overflow,
  output logic [ADDR_W:0]    level,
  input  logic               fft_rfd,
  output logic               fft_start,
  output logic [DATA_W-1:0]  xn_re,
  output logic [DATA_W-1:0]  xn_im,
  output logic               xn_valid,
  output logic [IDX_W-1:0]   xn_index,
  output logic               xn_last,
  output logic [SCALE_W-1:0] scale_sch,
  output logic               scale_sch_we,
  output logic               fwd_inv,
  output logic               fwd_inv_we
);

  localparam logic [ADDR_W:0]  DEPTH     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]  FRAME_LVL = (ADDR_W+1)'(FRAME_N);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_N - 1);

  typedef enum logic [1:0] {
    ST_CFG    = 2'd0,
    ST_IDLE   = 2'd1,
    ST_START  = 2'd2,
    ST_STREAM = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wptr_q, rptr_q;
  logic [ADDR_W:0]     level_q, level_d;
  logic                full_q, empty_q, overflow_q;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic                cfg_we_q, fft_start_q;
  logic                xn_valid_q, xn_last_q;
  logic [DATA_W-1:0]   xn_re_q;
  logic [IDX_W-1:0]    xn_index_q;
  logic                wr_en, pop_en;
  logic [DATA_W-1:0]   mem_q [0:(1<<ADDR_W)-1];

  // Offset binary to two's complement: invert the sign bit.
  function automatic logic [DATA_W-1:0] to_twos(input logic [DATA_W-1:0] s);
    return {~s[DATA_W-1], s[DATA_W-2:0]};
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop_en  = 1'b0;
    case (state_q)
      ST_CFG: state_d = ST_IDLE;
      ST_IDLE: begin
        if (level_q >= FRAME_LVL) state_d = ST_START;
        else                      state_d = ST_IDLE;
      end
      ST_START: begin
        state_d = ST_STREAM;
        cnt_d   = {IDX_W{1'b0}};
      end
      ST_STREAM: begin
        if (fft_rfd) begin
          pop_en = 1'b1;
          cnt_d  = cnt_q + IDX_W'(1);
          if (cnt_q == LAST_IDX) state_d = ST_IDLE;
          else                   state_d = ST_STREAM;
        end else begin
          state_d = ST_STREAM;
        end
      end
      default: state_d = ST_CFG;
    endcase
  end

  // A write on a full FIFO is dropped even when a pop happens the same cycle.
  always_comb begin
    wr_en = adc_valid && !full_q;
    case ({wr_en, pop_en})
      2'b10:   level_d = level_q + (ADDR_W+1)'(1);
      2'b01:   level_d = level_q - (ADDR_W+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= adc_data;
  end

  always_ff @(posedge clk) begin
    if (reset_fifo) begin
      state_q     <= ST_CFG;
      wptr_q      <= {ADDR_W{1'b0}};
      rptr_q      <= {ADDR_W{1'b0}};
      level_q     <= {(ADDR_W+1){1'b0}};
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      overflow_q  <= 1'b0;
      cnt_q       <= {IDX_W{1'b0}};
      cfg_we_q    <= 1'b0;
      fft_start_q <= 1'b0;
      xn_valid_q  <= 1'b0;
      xn_last_q   <= 1'b0;
      xn_re_q     <= {DATA_W{1'b0}};
      xn_index_q  <= {IDX_W{1'b0}};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      full_q      <= (level_d == DEPTH);
      empty_q     <= (level_d == {(ADDR_W+1){1'b0}});
      cfg_we_q    <= (state_q == ST_CFG);
      fft_start_q <= (state_d == ST_START);
      xn_valid_q  <= pop_en;
      xn_last_q   <= pop_en && (cnt_q == LAST_IDX);
      if (wr_en) wptr_q <= wptr_q + ADDR_W'(1);
      if (adc_valid && full_q) overflow_q <= 1'b1;
      // Registered RAM read: sample and its index emerge one cycle after the pop.
      if (pop_en) begin
        rptr_q     <= rptr_q + ADDR_W'(1);
        xn_re_q    <= to_twos(mem_q[rptr_q]);
        xn_index_q <= cnt_q;
      end
    end
  end

  assign full         = full_q;
  assign empty        = empty_q;
  assign overflow     = overflow_q;
  assign level        = level_q;
  assign fft_start    = fft_start_q;
  assign xn_re        = xn_re_q;
  assign xn_im        = {DATA_W{1'b0}};
  assign xn_valid     = xn_valid_q;
  assign xn_index     = xn_index_q;
  assign xn_last      = xn_last_q;
  assign scale_sch    = SCALE_SCH;
  assign scale_sch_we = cfg_we_q;
  assign fwd_inv      = FWD_INV;
  assign fwd_inv_we   = cfg_we_q;

endmodule
